// File: rtl/id_stage.sv
// Decode stage of a 5-stage MIPS-style pipeline: IF/ID register, 32x32 register file,
// load-use and branch hazard detection, early branch/jump resolution and the ID/EX register.
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter bit          BRANCH_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic [31:0] instruction,
   input  logic        ex_mem_read,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_write_reg,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_write_reg,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_write_reg,
   input  logic [31:0] wb_write_data,
   output logic        stall,
   output logic [31:0] pc_decode,
   output logic        pc_src,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_rs_data,
   output logic [31:0] id_ex_rt_data,
   output logic [31:0] id_ex_imm,
   output logic [14:0] id_ex_regs,
   output logic [11:0] id_ex_ctrl
);

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic        id_ex_valid_q, id_ex_valid_d;
   logic [31:0] id_ex_rs_data_q, id_ex_rs_data_d;
   logic [31:0] id_ex_rt_data_q, id_ex_rt_data_d;
   logic [31:0] id_ex_imm_q, id_ex_imm_d;
   logic [14:0] id_ex_regs_q, id_ex_regs_d;
   logic [11:0] id_ex_ctrl_q, id_ex_ctrl_d;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext, rs_data, rt_data, br_target, j_target, target;
   logic        is_branch, rs_busy, rt_busy, load_use, branch_hz, taken;
   logic        unused_shamt;

   assign opcode       = if_id_instr_q[31:26];
   assign rs           = if_id_instr_q[25:21];
   assign rt           = if_id_instr_q[20:16];
   assign rd           = if_id_instr_q[15:11];
   assign funct        = if_id_instr_q[5:0];
   assign unused_shamt = ^if_id_instr_q[10:6];
   assign imm_sext     = {{16{if_id_instr_q[15]}}, if_id_instr_q[15:0]};

   // Write-through lets an instruction in decode see the value being written back this cycle.
   assign rs_data = (rs == 5'd0) ? 32'd0 :
                    (wb_reg_write && wb_write_reg == rs) ? wb_write_data : regs_q[rs];
   assign rt_data = (rt == 5'd0) ? 32'd0 :
                    (wb_reg_write && wb_write_reg == rt) ? wb_write_data : regs_q[rt];

   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign rs_busy   = (rs != 5'd0) && ((ex_reg_write && ex_write_reg == rs) ||
                                       (mem_reg_write && mem_write_reg == rs));
   assign rt_busy   = (rt != 5'd0) && ((ex_reg_write && ex_write_reg == rt) ||
                                       (mem_reg_write && mem_write_reg == rt));
   assign load_use  = if_id_valid_q && ex_mem_read && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == rs) || (ex_write_reg == rt));
   assign branch_hz = if_id_valid_q && is_branch && (rs_busy || rt_busy);
   assign stall     = load_use || branch_hz;

   assign br_target = if_id_pc_q + {imm_sext[29:0], 2'b00};
   assign j_target  = {if_id_pc_q[31:28], if_id_instr_q[25:0], 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = 32'd0;
      case (opcode)
         OP_BEQ: begin
            taken  = (rs_data == rt_data);
            target = br_target;
         end
         OP_BNE: begin
            taken  = (rs_data != rt_data);
            target = br_target;
         end
         OP_J: begin
            taken  = 1'b1;
            target = j_target;
         end
         default: ;
      endcase
   end

   assign pc_src    = if_id_valid_q && !stall && BRANCH_EN && taken;
   assign pc_decode = pc_src ? target : 32'd0;

   // IF/ID: hold on stall, squash the fetched word behind a taken branch/jump.
   always_comb begin
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      if (!stall) begin
         if (pc_src) begin
            if_id_pc_d    = 32'd0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
         end else begin
            if_id_pc_d    = pc_next;
            if_id_instr_d = instruction;
            if_id_valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
      if (wb_reg_write && wb_write_reg != 5'd0) regs_d[wb_write_reg] = wb_write_data;
   end

   // ID/EX: bubble unless a valid instruction leaves decode this cycle.
   always_comb begin
      id_ex_valid_d   = 1'b0;
      id_ex_rs_data_d = 32'd0;
      id_ex_rt_data_d = 32'd0;
      id_ex_imm_d     = 32'd0;
      id_ex_regs_d    = 15'd0;
      id_ex_ctrl_d    = 12'd0;
      if (if_id_valid_q && !stall) begin
         id_ex_valid_d   = 1'b1;
         id_ex_rs_data_d = rs_data;
         id_ex_rt_data_d = rt_data;
         id_ex_imm_d     = imm_sext;
         id_ex_regs_d    = {rs, rt, rd};
         id_ex_ctrl_d    = {opcode, funct};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_pc_q      <= 32'd0;
         if_id_instr_q   <= NOP_INSTR;
         if_id_valid_q   <= 1'b0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
         id_ex_valid_q   <= 1'b0;
         id_ex_rs_data_q <= 32'd0;
         id_ex_rt_data_q <= 32'd0;
         id_ex_imm_q     <= 32'd0;
         id_ex_regs_q    <= 15'd0;
         id_ex_ctrl_q    <= 12'd0;
      end else begin
         if_id_pc_q      <= if_id_pc_d;
         if_id_instr_q   <= if_id_instr_d;
         if_id_valid_q   <= if_id_valid_d;
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
         id_ex_valid_q   <= id_ex_valid_d;
         id_ex_rs_data_q <= id_ex_rs_data_d;
         id_ex_rt_data_q <= id_ex_rt_data_d;
         id_ex_imm_q     <= id_ex_imm_d;
         id_ex_regs_q    <= id_ex_regs_d;
         id_ex_ctrl_q    <= id_ex_ctrl_d;
      end
   end

   assign id_ex_valid   = id_ex_valid_q;
   assign id_ex_rs_data = id_ex_rs_data_q;
   assign id_ex_rt_data = id_ex_rt_data_q;
   assign id_ex_imm     = id_ex_imm_q;
   assign id_ex_regs    = id_ex_regs_q;
   assign id_ex_ctrl    = id_ex_ctrl_q;

endmodule
